// File: rtl/bram_rd_burst_ctrl.sv
// Burst read initiator for a fixed-latency BRAM read port, returning words through a credit-protected FWFT buffer.
// Defining BRAM_RD_BURST_CTRL_STAT_EN adds saturating output-stall and credit-stall counters.
module bram_rd_burst_ctrl #(
    parameter int RD_ADDR_WDT  = 10,
    parameter int DATA_OUT_WDT = 64,
    parameter int PIPE_IN_CNT  = 1,
    parameter int PIPE_OUT_CNT = 1,
    parameter int LEN_WDT      = 11,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [RD_ADDR_WDT-1:0]  cmd_base_addr,
    input  logic [LEN_WDT-1:0]      cmd_len,
    output logic                    mem_rd_en,
    output logic [RD_ADDR_WDT-1:0]  mem_rd_addr,
    input  logic [DATA_OUT_WDT-1:0] mem_data_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_OUT_WDT-1:0] out_data,
    output logic                    out_last,
    output logic                    busy
`ifdef BRAM_RD_BURST_CTRL_STAT_EN
    ,
    output logic [31:0]             stat_stall_cnt,
    output logic [31:0]             stat_credit_stall_cnt
`endif
);

    localparam int RD_LAT = PIPE_IN_CNT + PIPE_OUT_CNT + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state, state_n;
    logic [RD_ADDR_WDT-1:0]  addr_n;
    logic [LEN_WDT-1:0]      rem, rem_n;
    logic [CNT_W-1:0]        used, used_n;
    logic [CNT_W-1:0]        fifo_cnt, fifo_cnt_n;
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [RD_LAT-1:0]       vld_p, last_p;
    logic [DATA_OUT_WDT-1:0] fifo_data [FIFO_DEPTH];
    logic                    fifo_last [FIFO_DEPTH];
    logic                    cmd_hs, cmd_go, push, pop, issue_last;

    always_ff @(posedge clk) begin
        assert (FIFO_DEPTH >= RD_LAT + 1 && (FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0)
            else $fatal(1, "bram_rd_burst_ctrl: FIFO_DEPTH must be a power of 2 and >= RD_LAT+1");
    end

    // `used` is in-flight reads plus buffered words; it only drops on a pop,
    // so a read issued now always has a slot reserved when it returns.
    always_comb begin
        cmd_hs     = cmd_valid && cmd_ready;
        cmd_go     = cmd_hs && (cmd_len != '0);
        pop        = (fifo_cnt != '0) && out_ready;
        push       = vld_p[RD_LAT-1];
        issue_last = mem_rd_en && (rem == LEN_WDT'(1));
        used_n     = used + CNT_W'(mem_rd_en) - CNT_W'(pop);
        fifo_cnt_n = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        state_n    = state;
        addr_n     = mem_rd_addr;
        rem_n      = rem;
        case (state)
            IDLE: begin
                if (cmd_go) begin
                    state_n = RUN;
                    addr_n  = cmd_base_addr;
                    rem_n   = cmd_len;
                end
            end
            RUN: begin
                if (mem_rd_en) begin
                    addr_n = mem_rd_addr + 1'b1;
                    rem_n  = rem - 1'b1;
                    if (rem == LEN_WDT'(1)) state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from next-state values, so mem_rd_en reflects
    // the credit check against the counts of the cycle in which it is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            rem         <= '0;
            used        <= '0;
            fifo_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            vld_p       <= '0;
            last_p      <= '0;
        end else begin
            state       <= state_n;
            cmd_ready   <= (state_n == IDLE);
            busy        <= (state_n != IDLE);
            mem_rd_en   <= (state_n == RUN) && (used_n < DEPTH_C);
            mem_rd_addr <= addr_n;
            rem         <= rem_n;
            used        <= used_n;
            fifo_cnt    <= fifo_cnt_n;
            vld_p       <= (vld_p << 1) | RD_LAT'(mem_rd_en);
            last_p      <= (last_p << 1) | RD_LAT'(issue_last);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_data_out;
            fifo_last[wr_ptr] <= last_p[RD_LAT-1];
        end
    end

    assign out_valid = (fifo_cnt != '0);
    assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last  = out_valid && fifo_last[rd_ptr];

`ifdef BRAM_RD_BURST_CTRL_STAT_EN
    always_ff @(posedge clk) begin
        if (rst || cmd_go) begin
            stat_stall_cnt        <= '0;
            stat_credit_stall_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stat_stall_cnt != '1)
                stat_stall_cnt <= stat_stall_cnt + 1'b1;
            if (state == RUN && !mem_rd_en && stat_credit_stall_cnt != '1)
                stat_credit_stall_cnt <= stat_credit_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bram_rd_burst_ctrl.sv
// Randomized self-checking bench for bram_rd_burst_ctrl against a queue-based burst model and a 3-cycle BRAM model.
module tb_bram_rd_burst_ctrl;

    localparam int AW = 10, DW = 64, LW = 11, DEPTH = 8, RD_LAT = 3;

    logic          clk = 1'b0, rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [AW-1:0] cmd_base_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_data_out = '0;
    logic          out_valid, out_ready = 1'b1, out_last, busy;
    logic [DW-1:0] out_data;
`ifdef BRAM_RD_BURST_CTRL_STAT_EN
    logic [31:0]   stat_stall_cnt, stat_credit_stall_cnt;
`endif

    int n_cmp = 0, n_err = 0;
    bit rand_ready = 1'b0;

    always #5 clk = ~clk;

    bram_rd_burst_ctrl #(.RD_ADDR_WDT(AW), .DATA_OUT_WDT(DW), .PIPE_IN_CNT(1), .PIPE_OUT_CNT(1),
                         .LEN_WDT(LW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base_addr(cmd_base_addr), .cmd_len(cmd_len), .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr), .mem_data_out(mem_data_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy)
`ifdef BRAM_RD_BURST_CTRL_STAT_EN
        , .stat_stall_cnt(stat_stall_cnt), .stat_credit_stall_cnt(stat_credit_stall_cnt)
`endif
    );

    // BRAM with mem[a] = a: input register, array read, output register
    logic [AW-1:0] bram_a0 = '0, bram_a1 = '0;
    always @(posedge clk) begin
        bram_a0      <= mem_rd_addr;
        bram_a1      <= bram_a0;
        mem_data_out <= DW'(bram_a1);
    end

    always @(posedge clk) begin
        #2;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    logic [DW-1:0] obs_data[$];
    bit            obs_last[$];
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] exp_addr[$];
    bit            exp_last[$];
    int outstanding = 0, max_outstanding = 0;

    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
        end else begin
            if (mem_rd_en) begin
                rd_q.push_back(mem_rd_addr);
                outstanding++;
            end
            if (out_valid && out_ready) begin
                obs_data.push_back(out_data);
                obs_last.push_back(out_last);
                outstanding--;
            end
            if (outstanding > max_outstanding) max_outstanding = outstanding;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic clear_mon();
        obs_data.delete(); obs_last.delete(); rd_q.delete();
        exp_addr.delete(); exp_last.delete();
        max_outstanding = outstanding;
    endtask

    // reference: a burst reads base, base+1, ... modulo 2^AW, last flag on the final word
    task automatic model_burst(input logic [AW-1:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            exp_addr.push_back(AW'(int'(base) + i));
            exp_last.push_back(i == len - 1);
        end
    endtask

    task automatic send_cmd(input logic [AW-1:0] base, input logic [LW-1:0] len, output int waits);
        waits = 0;
        while (!cmd_ready && waits < 500) begin @(posedge clk); #1; waits++; end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waits);
        end
        cmd_valid = 1'b1; cmd_base_addr = base; cmd_len = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int nwords);
        int cyc = 0;
        while ((obs_data.size() < nwords || busy) && cyc < 3000) begin @(posedge clk); #1; cyc++; end
        n_cmp++;
        if (obs_data.size() < nwords || busy !== 1'b0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d words busy=%b, required %0d words busy=0",
                     obs_data.size(), busy, nwords);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({cmd_ready, mem_rd_en, out_valid, out_last, busy} !== 5'b0 || mem_rd_addr !== '0 || out_data !== '0) begin
            n_err++;
            $display("FAIL reset_values: rdy=%b en=%b addr=%h vld=%b last=%b data=%h busy=%b, required all 0",
                     cmd_ready, mem_rd_en, mem_rd_addr, out_valid, out_last, out_data, busy);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: cmd_ready=%b busy=%b, required 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_single_burst();
        int waits, lat;
        clear_mon();
        out_ready = 1'b1;
        send_cmd(10'h010, 11'd16, waits);
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        n_cmp++;
        if (lat != RD_LAT + 1) begin
            n_err++;
            $display("FAIL first_latency: %0d cycles, required %0d", lat, RD_LAT + 1);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== DW'(16 + i) || out_last !== 1'(i == 15)) begin
                n_err++;
                $display("FAIL burst_word%0d: vld=%b data=%h last=%b, required 1/%h/%b",
                         i, out_valid, out_data, out_last, DW'(16 + i), i == 15);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL burst_end: busy=%b cmd_ready=%b, required 0/1", busy, cmd_ready);
        end
    endtask

    task automatic test_wrap();
        int waits;
        clear_mon();
        model_burst(10'h3FE, 4);
        send_cmd(10'h3FE, 11'd4, waits);
        wait_drain(4);
        n_cmp++;
        if (rd_q.size() != 4 || obs_data.size() != 4) begin
            n_err++;
            $display("FAIL wrap_count: reads=%0d words=%0d, required 4/4", rd_q.size(), obs_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (rd_q[i] !== exp_addr[i] || obs_data[i] !== DW'(exp_addr[i]) || obs_last[i] !== exp_last[i]) begin
                    n_err++;
                    $display("FAIL wrap_word%0d: addr=%h data=%h last=%b, required %h/%h/%b",
                             i, rd_q[i], obs_data[i], obs_last[i], exp_addr[i], DW'(exp_addr[i]), exp_last[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int waits, bad;
        logic [AW-1:0] base;
        clear_mon();
        base = AW'($urandom);
        model_burst(base, 32);
        out_ready = 1'b0;
        send_cmd(base, 11'd32, waits);
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (rd_q.size() != DEPTH || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL stall_reads: reads=%0d cmd_ready=%b busy=%b, required %0d/0/1",
                     rd_q.size(), cmd_ready, busy, DEPTH);
        end
`ifdef BRAM_RD_BURST_CTRL_STAT_EN
        n_cmp++;
        if (stat_stall_cnt !== 32'(20 - RD_LAT - 1)) begin
            n_err++;
            $display("FAIL stat_stall: %0d, required %0d", stat_stall_cnt, 20 - RD_LAT - 1);
        end
`endif
        out_ready = 1'b1;
        wait_drain(32);
        bad = 0;
        for (int i = 0; i < 32; i++)
            if (i >= obs_data.size() || obs_data[i] !== DW'(exp_addr[i]) || obs_last[i] !== exp_last[i]) bad++;
        n_cmp++;
        if (bad != 0 || obs_data.size() != 32 || rd_q.size() != 32 || max_outstanding > DEPTH) begin
            n_err++;
            $display("FAIL stall_stream: bad=%0d words=%0d reads=%0d max_out=%0d, required 0/32/32/<=%0d",
                     bad, obs_data.size(), rd_q.size(), max_outstanding, DEPTH);
        end
`ifdef BRAM_RD_BURST_CTRL_STAT_EN
        clear_mon();
        send_cmd(10'h050, 11'd1, waits);
        n_cmp++;
        if (stat_stall_cnt !== 32'd0 || stat_credit_stall_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL stat_clear: stall=%0d credit=%0d, required 0/0", stat_stall_cnt, stat_credit_stall_cnt);
        end
        wait_drain(1);
`endif
    endtask

    task automatic test_zero_len();
        int waits;
        clear_mon();
        out_ready = 1'b1;
        send_cmd(10'h123, 11'd0, waits);
        n_cmp++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL zero_len_idle: busy=%b cmd_ready=%b, required 0/1", busy, cmd_ready);
        end
        send_cmd(10'h2A5, 11'd1, waits);
        n_cmp++;
        if (waits != 0) begin
            n_err++;
            $display("FAIL zero_len_next: accepted after %0d waits, required 0", waits);
        end
        wait_drain(1);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (rd_q.size() != 1 || obs_data.size() != 1 || rd_q[0] !== 10'h2A5 || obs_data[0] !== DW'(10'h2A5)) begin
            n_err++;
            $display("FAIL zero_len_reads: reads=%0d words=%0d, required exactly one read/word of 2a5",
                     rd_q.size(), obs_data.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        int waits, vld_seen;
        out_ready = 1'b1;
        send_cmd(10'h200, 11'd32, waits);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_mon();
        vld_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0) vld_seen++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (vld_seen != 0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: valid cycles=%0d cmd_ready=%b busy=%b, required 0/1/0", vld_seen, cmd_ready, busy);
        end
        send_cmd(10'h100, 11'd2, waits);
        wait_drain(2);
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_data.size() != 2 || obs_data[0] !== DW'(10'h100) || obs_data[1] !== DW'(10'h101)
            || obs_last[0] !== 1'b0 || obs_last[1] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_new_burst: words=%0d first=%h, required 2 words 100,101",
                     obs_data.size(), obs_data.size() > 0 ? obs_data[0] : '0);
        end
    endtask

    task automatic test_random();
        int waits, len, bad;
        logic [AW-1:0] base;
        rand_ready = 1'b1;
        for (int b = 0; b < 25; b++) begin
            clear_mon();
            base = AW'($urandom);
            len  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            model_burst(base, len);
            send_cmd(base, LW'(len), waits);
            wait_drain(len);
            repeat (5) @(posedge clk);
            #1;
            bad = 0;
            for (int i = 0; i < len; i++)
                if (i >= obs_data.size() || i >= rd_q.size() || rd_q[i] !== exp_addr[i]
                    || obs_data[i] !== DW'(exp_addr[i]) || obs_last[i] !== exp_last[i]) bad++;
            n_cmp++;
            if (bad != 0 || obs_data.size() != len || rd_q.size() != len || max_outstanding > DEPTH) begin
                n_err++;
                $display("FAIL random_burst%0d: base=%h len=%0d bad=%0d words=%0d reads=%0d max_out=%0d",
                         b, base, len, bad, obs_data.size(), rd_q.size(), max_outstanding);
            end
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
